// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD read and write controllers.
// State encodings, busy-flag position and register-select values.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } lcd_state_t;

  localparam int   LCD_BUSY_BIT = 7;
  localparam logic LCD_RS_CMD   = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;

  function automatic logic lcd_is_busy(input logic [7:0] status);
    return status[LCD_BUSY_BIT];
  endfunction

endpackage

// File: rtl/lcd_start_detect.sv
// Rising-edge detector for LCD transaction requests; one-cycle pulse, registered history.
// Latency: combinational from i_level; no backpressure (caller gates on its own state).
module lcd_start_detect (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic i_level,
  output logic o_rise
);

  logic r_pre;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_pre <= 1'b0;
    else         r_pre <= i_level;
  end

  assign o_rise = i_level & ~r_pre;

endmodule

// File: rtl/lcd_reader.sv
// HD44780 bus read: one RW=1 cycle per accepted iStart edge, oDone after CLK_Divide+3 cycles.
// Starts arriving while busy are dropped; LCD_READER_BUSY_POLL_EN repeats RS=0 reads while busy.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int CLK_Divide = 16,
  parameter int MAX_POLL   = 255
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iRS,
  input  logic       iStart,
  output logic [7:0] oDATA,
  output logic       oDone,
  output logic       oTimeout,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam logic [4:0] CONT_MAX = 5'(CLK_Divide);

  if (CLK_Divide < 1 || CLK_Divide > 31 || MAX_POLL < 1 || MAX_POLL > 255) begin : g_bad_cfg
    $error("lcd_reader: CLK_Divide must be 1..31 and MAX_POLL 1..255");
  end

  lcd_state_t r_state;
  logic [4:0] r_cont;
  logic       w_rise;

  lcd_start_detect u_start_detect (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .i_level (iStart),
    .o_rise  (w_rise)
  );

`ifdef LCD_READER_BUSY_POLL_EN
  localparam logic [8:0] POLL_LIMIT = 9'(MAX_POLL);
  logic [7:0] r_poll;
`else
  assign oTimeout = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= ST_IDLE;
      r_cont   <= 5'd0;
      oDATA    <= 8'd0;
      oDone    <= 1'b0;
      LCD_RW   <= 1'b0;
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
`ifdef LCD_READER_BUSY_POLL_EN
      r_poll   <= 8'd0;
      oTimeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            LCD_RS  <= iRS;
            LCD_RW  <= 1'b1;
            oDone   <= 1'b0;
            r_state <= ST_SETUP;
`ifdef LCD_READER_BUSY_POLL_EN
            oTimeout <= 1'b0;
            r_poll   <= 8'd0;
`endif
          end
        end
        // RS/RW have had a full cycle of setup by the time EN rises here.
        ST_SETUP: begin
          LCD_EN  <= 1'b1;
          r_cont  <= 5'd0;
          r_state <= ST_PULSE;
        end
        ST_PULSE: begin
          if (r_cont == CONT_MAX) begin
            oDATA   <= LCD_DATA_IN;
            LCD_EN  <= 1'b0;
            r_state <= ST_HOLD;
          end else begin
            r_cont <= r_cont + 5'd1;
          end
        end
        ST_HOLD: begin
`ifdef LCD_READER_BUSY_POLL_EN
          if (LCD_RS == LCD_RS_CMD && lcd_is_busy(oDATA)) begin
            if (({1'b0, r_poll} + 9'd1) < POLL_LIMIT) begin
              r_poll  <= r_poll + 8'd1;
              r_state <= ST_SETUP;
            end else begin
              LCD_RW   <= 1'b0;
              oDone    <= 1'b1;
              oTimeout <= 1'b1;
              r_cont   <= 5'd0;
              r_state  <= ST_IDLE;
            end
          end else begin
            LCD_RW  <= 1'b0;
            oDone   <= 1'b1;
            r_cont  <= 5'd0;
            r_state <= ST_IDLE;
          end
`else
          LCD_RW  <= 1'b0;
          oDone   <= 1'b1;
          r_cont  <= 5'd0;
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Read-side counterpart of the team's write-only character-LCD controller.
- Performs one HD44780-style bus read cycle per iStart rising edge: RW=1, latched RS, timed EN pulse, sample of LCD data, oDone handshake.
- Used to read the busy flag/address counter (RS=0) or DDRAM/CGRAM data (RS=1).
- Sits beside the write controller under the LCD top level. The top level tristates its LCD_DATA pad driver whenever LCD_RW=1.

Parameters:
- CLK_Divide, 16: EN high time minus one, in iCLK cycles. Legal range 1..31.
- MAX_POLL, 255: maximum busy-flag read attempts. Used only with the optional feature; legal range 1..255.

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous reset, active-low
- iRS  in  1  register select for the read; 0 = busy flag/address, 1 = data
- iStart  in  1  request; a rising edge starts one transaction
- oDATA  out  8  captured read byte
- oDone  out  1  transaction complete; held until the next accepted start
- oTimeout  out  1  busy-poll gave up; 0 when the optional feature is off
- LCD_DATA_IN  in  8  LCD data bus input, from the pad
- LCD_RW  out  1  1 = read cycle in progress
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  registered register select

Behaviour:
- Reset (async, iRST_N=0): oDATA=0, oDone=0, oTimeout=0, LCD_RW=0, LCD_EN=0, LCD_RS=0, counters=0, state=IDLE.
- Reset asserted mid-transaction aborts immediately. EN and RW drop asynchronously.
- Start detect: preStart is iStart registered every cycle. A start is accepted when {preStart,iStart}==01 and state==IDLE.
- Edges seen in any other state are ignored. No queuing.
- States: IDLE, SETUP, PULSE, HOLD. All outputs are registered.
- Timing, with edge 0 = the edge that accepts the start:
  - Edge 0: LCD_RS<=iRS, LCD_RW<=1, oDone<=0, oTimeout<=0, state<=SETUP. This gives one full cycle of RS/RW setup before EN.
  - Edge 1 (SETUP): LCD_EN<=1, Cont<=0, state<=PULSE.
  - PULSE: Cont increments while Cont<CLK_Divide.
  - When Cont==CLK_Divide: oDATA<=LCD_DATA_IN, LCD_EN<=0, state<=HOLD. This occurs at edge CLK_Divide+2.
  - EN is therefore high for exactly CLK_Divide+1 cycles, and data is sampled on the final EN-high cycle.
  - HOLD, single-read path: LCD_RW<=0, oDone<=1, Cont<=0, state<=IDLE. RS/RW hold for one cycle after EN falls.
- oDone rises at edge CLK_Divide+3 after acceptance; 19 cycles at the default.
- oDATA is stable from oDone rising until the next accepted transaction's sample edge.
- Cont width is 5 bits. It never wraps because CLK_Divide≤31.
- iRS changes after edge 0 have no effect on the current transaction.
- A start edge arriving in the same cycle the state returns to IDLE is ignored, because state!=IDLE on that edge.

Optional Feature:
- Macro: LCD_READER_BUSY_POLL_EN.
- Defined, and the transaction was started with iRS=0:
  - In HOLD, if captured bit 7 (busy flag)==1 and Poll+1<MAX_POLL: Poll<=Poll+1, LCD_RW stays 1, state<=SETUP (a new EN pulse follows).
  - If bit7==1 and Poll+1==MAX_POLL: finish with oDone=1 and oTimeout=1.
  - If bit7==0: finish normally.
  - Poll is an 8-bit counter, cleared at start acceptance.
- Defined, iRS=1: identical to a single read.
- Not defined: single read always. oTimeout is a constant 0 and no Poll register exists.

Decomposition:
- Shared package lcd_pkg holds:
  - state encodings ST_IDLE=0, ST_SETUP=1, ST_PULSE=2, ST_HOLD=3;
  - LCD_BUSY_BIT=7;
  - RS constants LCD_RS_CMD=0 and LCD_RS_DATA=1.
- These are also used by the write controller.
- One natural sub-module: lcd_start_detect. It is the rising-edge detector (preStart register plus AND), shared with the write controller.

Test Plan:
- Reset mid-PULSE at CLK_Divide=16: drop iRST_N at cycle 8 -> LCD_EN=0, LCD_RW=0, oDone=0 immediately. A new start after release completes normally.
- Basic data read: iRS=1, LCD_DATA_IN=8'h41, iStart 0->1 at edge 0 -> LCD_RS=1 and LCD_RW=1 from edge 0; EN high edges 1..18 (17 cycles); oDATA=8'h41; oDone=1 at edge 19; LCD_RW=0 at edge 19.
- Level-held start: iStart held 1 for 100 cycles -> exactly one EN pulse. A second 0->1 edge issued during PULSE -> ignored. A new edge after oDone -> second transaction, with oDone cleared at its accept edge.
- CLK_Divide=1 corner: EN high exactly 2 cycles; oDone at edge 4.
- Busy poll (macro defined, MAX_POLL=4, iRS=0):
  - LCD_DATA_IN=8'h80 for the first two pulses, then 8'h05 -> three EN pulses; oDATA=8'h05; oTimeout=0.
  - LCD_DATA_IN held at 8'h80 -> four pulses, then oDone=1 and oTimeout=1.
- Macro undefined, same 8'h80 stimulus -> one pulse; oDATA=8'h80; oTimeout=0.
